// File: rtl/terminal_ctrl.sv
// terminal_ctrl: turns a keyboard ASCII stream into character VRAM write
// strobes. Handles printable text, backspace, newline, form-feed clear,
// line clear on newline/wrap, full clear after reset and key auto-repeat.
module terminal_ctrl #(
    parameter int         ROWS          = 30,
    parameter int         COLS          = 70,
    parameter int         REPEAT_DELAY  = 25000000,
    parameter int         REPEAT_PERIOD = 2500000,
    parameter logic [2:0] FG            = 3'd7,
    parameter logic [2:0] BG            = 3'd0,
    localparam int        ROW_W         = $clog2(ROWS),
    localparam int        COL_W         = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_ascii,
    output logic             in_ready,
    output logic             we,
    output logic [ROW_W-1:0] wr_addr,
    output logic [COL_W-1:0] wc_addr,
    output logic [7:0]       w_ascii,
    output logic [2:0]       fg_color,
    output logic [2:0]       bg_color,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    typedef enum logic [1:0] {IDLE, HOLD, CLR_ROW, CLR_ALL} state_t;

    state_t           state;
    logic [7:0]       key;        // code latched at the last fresh accept
    logic [31:0]      rep_cnt;
    logic             rep_fast;   // first repeat already happened
    logic             from_rst;   // current full clear was started by reset
    logic [ROW_W-1:0] clr_r;
    logic [COL_W-1:0] clr_c;
    logic             clr_end;    // last clear write issued, leave next cycle

    logic [7:0]       acc_code;
    logic             do_acc;
    logic             a_we;
    logic [ROW_W-1:0] a_wr, a_crow, row_nxt;
    logic [COL_W-1:0] a_wc, a_ccol;
    logic [7:0]       a_dat;
    state_t           a_state;
    logic [31:0]      rep_lim;

    assign fg_color = FG;
    assign bg_color = BG;

    // Outcome of accepting acc_code at the current cursor (fresh key or repeat)
    always_comb begin
        acc_code = (state == IDLE) ? in_ascii : key;
        rep_lim  = rep_fast ? 32'(REPEAT_PERIOD) : 32'(REPEAT_DELAY);
        do_acc   = ((state == IDLE) && in_valid) ||
                   ((state == HOLD) && in_valid && (in_ascii == key) && (rep_cnt == rep_lim));
        row_nxt  = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
        a_we     = 1'b0;
        a_wr     = cur_row;
        a_wc     = cur_col;
        a_dat    = acc_code;
        a_crow   = cur_row;
        a_ccol   = cur_col;
        a_state  = HOLD;
        if (acc_code >= 8'h20 && acc_code <= 8'h7E) begin
            a_we = 1'b1;
            if (cur_col == COL_LAST) begin
                a_ccol  = '0;
                a_crow  = row_nxt;
                a_state = CLR_ROW;
            end else begin
                a_ccol = cur_col + 1'b1;
            end
        end else if (acc_code == 8'h0A) begin
            a_ccol  = '0;
            a_crow  = row_nxt;
            a_state = CLR_ROW;
        end else if (acc_code == 8'h08) begin
            a_dat = 8'h20;
            if (cur_col != '0) begin
                a_we   = 1'b1;
                a_ccol = cur_col - 1'b1;
                a_wc   = cur_col - 1'b1;
            end else if (cur_row != '0) begin
                a_we   = 1'b1;
                a_crow = cur_row - 1'b1;
                a_ccol = COL_LAST;
                a_wr   = cur_row - 1'b1;
                a_wc   = COL_LAST;
            end
        end else if (acc_code == 8'h0C) begin
            a_crow  = '0;
            a_ccol  = '0;
            a_state = CLR_ALL;
        end
    end

    // Control FSM with registered write port, cursor and handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLR_ALL;
            from_rst <= 1'b1;
            in_ready <= 1'b0;
            we       <= 1'b0;
            wr_addr  <= '0;
            wc_addr  <= '0;
            w_ascii  <= '0;
            cur_row  <= '0;
            cur_col  <= '0;
            rep_cnt  <= '0;
            rep_fast <= 1'b0;
            key      <= '0;
            clr_r    <= '0;
            clr_c    <= '0;
            clr_end  <= 1'b0;
        end else begin
            we <= 1'b0;
            if (do_acc) begin
                if (state == IDLE) key <= in_ascii;
                else               rep_fast <= 1'b1;
                we       <= a_we;
                wr_addr  <= a_wr;
                wc_addr  <= a_wc;
                w_ascii  <= a_dat;
                cur_row  <= a_crow;
                cur_col  <= a_ccol;
                state    <= a_state;
                in_ready <= 1'b0;
                rep_cnt  <= '0;
                clr_r    <= '0;
                clr_c    <= '0;
                clr_end  <= 1'b0;
                from_rst <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    HOLD: begin
                        if (!in_valid || in_ascii != key) begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                            rep_fast <= 1'b0;
                        end else begin
                            rep_cnt <= rep_cnt + 32'd1;
                        end
                    end
                    CLR_ROW: begin
                        if (clr_end) begin
                            state   <= HOLD;
                            rep_cnt <= '0;
                        end else begin
                            we      <= 1'b1;
                            wr_addr <= cur_row;
                            wc_addr <= clr_c;
                            w_ascii <= 8'h20;
                            if (clr_c == COL_LAST) clr_end <= 1'b1;
                            else                   clr_c   <= clr_c + 1'b1;
                        end
                    end
                    CLR_ALL: begin
                        if (clr_end) begin
                            state    <= from_rst ? IDLE : HOLD;
                            in_ready <= from_rst;
                            from_rst <= 1'b0;
                            rep_cnt  <= '0;
                        end else begin
                            we      <= 1'b1;
                            wr_addr <= clr_r;
                            wc_addr <= clr_c;
                            w_ascii <= 8'h20;
                            if (clr_c == COL_LAST) begin
                                clr_c <= '0;
                                if (clr_r == ROW_LAST) clr_end <= 1'b1;
                                else                   clr_r   <= clr_r + 1'b1;
                            end else begin
                                clr_c <= clr_c + 1'b1;
                            end
                        end
                    end
                    default: state <= CLR_ALL;
                endcase
            end
        end
    end

endmodule
